// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fib_seq_ctrl
// Description : Streams the first N Fibonacci terms F(0)..F(N-1) over a
//               valid/ready output port. The sequence is cut short, with a
//               sticky overflow flag, if the next term would not fit in WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_run  = 2'd1;
    localparam logic [1:0]       c_st_done = 2'd2;
    localparam logic [WIDTH-1:0] c_b_init  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_n;
    logic             r_ovf;
    logic             r_ovf_pending;

    logic             w_cmd_hs;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_n_m1;
    logic [WIDTH:0]   w_sum;

    // Handshakes, final-term detection and the carry-preserving sum
    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_xfer   = out_valid && out_ready;
    assign w_n_m1   = r_n - c_cnt_one;
    assign w_last   = (r_k == w_n_m1) || r_ovf_pending;
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

    assign cmd_ready = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_run);
    assign out_last  = out_valid && w_last;
    assign busy      = (r_state == c_st_run) || (r_state == c_st_done);
    // An abort arriving in DONE suppresses the completion pulse
    assign done      = (r_state == c_st_done) && !abort;
    assign out_data  = r_a;
    assign out_index = r_k;
    assign ovf       = r_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks a concurrent term transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    w_state_nxt = (cmd_count != '0) ? c_st_run : c_st_done;
                end
            end
            c_st_run: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (w_xfer && w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Term generator: loads on a command, advances one term per transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= c_b_init;
            r_k           <= '0;
            r_n           <= '0;
            r_ovf         <= 1'b0;
            r_ovf_pending <= 1'b0;
        end else if (w_cmd_hs) begin
            r_a           <= '0;
            r_b           <= c_b_init;
            r_k           <= '0;
            r_n           <= cmd_count;
            r_ovf         <= 1'b0;
            r_ovf_pending <= 1'b0;
        end else if ((r_state == c_st_run) && !abort && w_xfer) begin
            if (w_last) begin
                // Truncated only if the overflow stopped us before term N-1
                if (r_ovf_pending && (r_k < w_n_m1)) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_a <= r_b;
                r_b <= w_sum[WIDTH-1:0];
                r_k <= r_k + c_cnt_one;
                // Old b still fits and is emitted next, but nothing after it
                if (w_sum[WIDTH]) begin
                    r_ovf_pending <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_seq_ctrl
// Description : Directed self-checking bench for fib_seq_ctrl (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_index;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             ovf;

    int     n_run  = 0;
    int     n_fail = 0;
    longint fib[0:63];

    fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle (caller is in IDLE)
    task automatic issue(input int n);
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(n);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_term(input string tag, input int i, input logic exp_last);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(fib[i]));
        check({tag, "_index"}, 64'(out_index), 64'(i));
        check({tag, "_last"},  64'(out_last),  64'(exp_last));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"},  64'(out_last),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_ovf"},       64'(ovf),       64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_out_index"}, 64'(out_index), 64'd0);
    endtask

    initial begin
        int idx;
        int budget;
        logic [WIDTH-1:0] held_data;
        logic             stalled;

        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_values("reset");

        // N=10, consumer always ready
        out_ready = 1'b1;
        issue(10);
        for (int i = 0; i < 10; i++) begin
            check_term("n10", i, i == 9);
            step();
        end
        check("n10_done",      64'(done),      64'd1);
        check("n10_out_valid", 64'(out_valid), 64'd0);
        check("n10_busy",      64'(busy),      64'd1);
        check("n10_ovf",       64'(ovf),       64'd0);
        step();
        check("n10_idle_ready", 64'(cmd_ready), 64'd1);
        check("n10_idle_done",  64'(done),      64'd0);

        // N=0: straight to DONE
        issue(0);
        check("n0_valid", 64'(out_valid), 64'd0);
        check("n0_done",  64'(done),      64'd1);
        check("n0_ready", 64'(cmd_ready), 64'd0);
        step();
        check("n0_ready_back", 64'(cmd_ready), 64'd1);
        check("n0_done_clr",   64'(done),      64'd0);

        // N=60: overflow truncates after F(47)
        issue(60);
        for (int i = 0; i < 48; i++) begin
            check_term("n60", i, i == 47);
            step();
        end
        check("n60_done",  64'(done), 64'd1);
        check("n60_ovf",   64'(ovf),  64'd1);
        step();
        step();
        check("n60_ovf_sticky", 64'(ovf), 64'd1);

        // Spot check of the largest 32-bit term
        issue(48);
        for (int i = 0; i < 47; i++) step();
        check("f47_value", 64'(out_data),  64'd2971215073);
        check("f47_index", 64'(out_index), 64'd47);
        check("f47_last",  64'(out_last),  64'd1);
        step();
        check("n48_done", 64'(done), 64'd1);
        check("n48_no_ovf", 64'(ovf), 64'd0);
        step();

        // N=6 with random back-pressure
        out_ready = 1'b0;
        issue(6);
        check("n6_ovf_cleared", 64'(ovf), 64'd0);
        idx       = 0;
        budget    = 200;
        stalled   = 1'b0;
        held_data = '0;
        while (idx < 6 && budget > 0) begin
            out_ready = 1'($urandom_range(0, 1));
            check_term("n6", idx, idx == 5);
            if (stalled) check("n6_hold", 64'(out_data), 64'(held_data));
            stalled   = !out_ready;
            held_data = out_data;
            if (out_ready) idx++;
            step();
            budget--;
        end
        check("n6_budget_ok", 64'(idx), 64'd6);
        check("n6_done", 64'(done), 64'd1);
        step();

        // N=20 aborted at index 4
        out_ready = 1'b1;
        issue(20);
        for (int i = 0; i < 4; i++) begin
            check_term("ab", i, 1'b0);
            step();
        end
        check_term("ab", 4, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_valid", 64'(out_valid), 64'd0);
        check("ab_ready", 64'(cmd_ready), 64'd1);
        check("ab_done",  64'(done),      64'd0);
        check("ab_busy",  64'(busy),      64'd0);
        step();
        check("ab_done2", 64'(done), 64'd0);

        // Abort coinciding with a command in IDLE: command wins
        abort = 1'b1;
        issue(3);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_term("n3", i, i == 2);
            step();
        end
        check("n3_done", 64'(done), 64'd1);
        step();

        // Reset at index 7 of N=20
        issue(20);
        for (int i = 0; i < 7; i++) step();
        check_term("rs", 7, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("rs_after");
        step();
        check("rs_no_done", 64'(done), 64'd0);
        issue(2);
        check_term("rs_new", 0, 1'b0);
        step();
        check_term("rs_new", 1, 1'b1);
        step();
        check("rs_new_done", 64'(done), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of every Fibonacci term.
REQ-002 Parameter: CNT_W, default 8, bit width of the term count and term index.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  request for a new sequence.
REQ-006 cmd_count  input  CNT_W  number of terms N requested; sampled on command handshake.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 abort  input  1  synchronous cancel of the sequence in progress.
REQ-009 out_valid  output  1  out_data / out_index / out_last are valid.
REQ-010 out_ready  input  1  consumer accepts the current term.
REQ-011 out_data  output  WIDTH  current term F(k).
REQ-012 out_index  output  CNT_W  current term index k.
REQ-013 out_last  output  1  current term is the final term of the sequence.
REQ-014 busy  output  1  a sequence is in progress (state RUN or DONE).
REQ-015 done  output  1  one-cycle pulse at sequence completion.
REQ-016 ovf  output  1  sticky flag: sequence truncated by WIDTH overflow.

Function
REQ-017 The block SHALL implement a FSM with states IDLE, RUN and DONE, with cmd_ready=1 only in IDLE and out_valid=1 only in RUN.
REQ-018 Command handshake = cmd_valid&&cmd_ready: the block SHALL latch N, load a=0, b=1, k=0, clear ovf and ovf_pending, and go to RUN if N>0, else DONE.
REQ-019 Latency: out_valid SHALL rise on the cycle after the command handshake, showing out_data=0 and out_index=0.
REQ-020 The block SHALL drive out_data=a and out_index=k; term transfer = out_valid&&out_ready.
REQ-021 On transfer of a non-last term, the block SHALL update a<=b, b<=(a+b) truncated to WIDTH, k<=k+1, computing the sum at WIDTH+1 bits.
REQ-022 If the carry-out of a+b is 1 on a transfer, the block SHALL set ovf_pending, so that the next term (the old b) is the last term emitted.
REQ-023 out_last SHALL be 1 when k==N-1 or when ovf_pending=1.
REQ-024 On transfer with out_last=1, the block SHALL go to DONE, and SHALL set ovf=1 if ovf_pending=1 and k<N-1.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable; out_valid SHALL NOT drop before a transfer except on abort or rst.
REQ-027 cmd_valid SHALL be ignored outside IDLE, and no command queuing is required.
REQ-028 abort=1 in RUN or DONE SHALL force IDLE on the next edge, with no done pulse; out_valid=0 and cmd_ready=1 from that edge, and ovf unchanged.
REQ-029 abort=1 in IDLE SHALL have no effect; if abort and a command handshake coincide in IDLE, the command SHALL be accepted.
REQ-030 ovf SHALL hold its value until the next command handshake or rst.
REQ-031 With WIDTH=32, the largest term emitted SHALL be F(47)=2971215073 at index 47.

Reset
REQ-032 With rst=1, on the clock edge the block SHALL enter IDLE with cmd_ready=1, out_valid=0, out_last=0, busy=0, done=0 and ovf=0, and out_data=0, out_index=0, a=0, b=1, k=0 and ovf_pending=0.
REQ-033 rst SHALL take priority over abort and over any handshake.
REQ-034 rst asserted mid-sequence SHALL discard the sequence with no done pulse.

Verification
REQ-035 Command N=10, out_ready=1 -> out_valid from the cycle after the handshake; terms 0,1,1,2,3,5,8,13,21,34; out_last on index 9; done pulse on the next cycle; ovf=0.
REQ-036 Command N=0 -> no out_valid; done=1 on the cycle after the handshake; cmd_ready=1 one cycle later.
REQ-037 Command N=60, WIDTH=32 -> 48 terms; index 47 = 2971215073 with out_last=1; then done=1 and ovf=1 (sticky until the next command).
REQ-038 Command N=6 with out_ready toggling randomly -> output held stable while stalled; sequence 0,1,1,2,3,5 with no duplicated or skipped terms.
REQ-039 Command N=20, abort pulsed at index 4 -> IDLE next cycle; out_valid=0, no done pulse; a following command N=3 yields 0,1,1.
REQ-040 rst pulsed at index 7 of an N=20 command -> all outputs at their REQ-032 values; no done pulse; a new command restarts at 0.
